// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned FETCH_XLEN = 32;
    localparam int unsigned FETCH_ILEN = 32;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam int unsigned PC_STEP    = 4;

    // Default fetch-queue entry at the nominal widths; the top builds the same layout from its own XLEN/ILEN.
    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] pc_4;
        logic [FETCH_ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry synchronous FIFO of fetch entries with flush; pointers wrap modulo DEPTH.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = fetch_entry_t,
    localparam int unsigned PW     = $clog2(DEPTH),
    localparam int unsigned CW     = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  entry_t        push_data,
    output entry_t        head,
    output logic [CW-1:0] count
);

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Flush wins over both push and pop in the same cycle.
    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && (count != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read once count covers it.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit_q.sv
// Instruction-fetch stage: PC, credit-based imem issue, and a decoupling queue towards decode.
module fetch_unit_q
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = FETCH_XLEN,
    parameter int unsigned     ILEN     = FETCH_ILEN,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    localparam int unsigned    CW       = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid_in,
    input  logic [XLEN-1:0] redirect_target_in,
    output logic            imem_req_valid_out,
    input  logic            imem_req_ready_in,
    output logic [XLEN-1:0] imem_addr_out,
    input  logic            imem_rsp_valid_in,
    input  logic [ILEN-1:0] imem_rsp_data_in,
    output logic            fq_valid_out,
    input  logic            fq_ready_in,
    output logic [XLEN-1:0] fq_pc_out,
    output logic [XLEN-1:0] fq_pc_4_out,
    output logic [ILEN-1:0] fq_instr_out,
    output logic [CW-1:0]   fq_count_out
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_4;
        logic [ILEN-1:0] instr;
    } entry_t;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rsp_pc;
    logic            inflight;
    logic [CW-1:0]   count;
    logic            credit;
    logic            accept;
    logic            drop_c;
    logic            push;
    logic            pop;
    entry_t          push_entry;
    entry_t          head;
    logic            unused_c;

    assign unused_c = ^redirect_target_in[1:0];

    // Outstanding request counts against capacity, so every accepted fetch has a slot.
    assign credit = ((CW+1)'(count) + (CW+1)'(inflight)) < (CW+1)'(DEPTH);
    assign imem_req_valid_out = rst_n && !redirect_valid_in && credit;
    assign imem_addr_out      = pc;
    assign accept             = imem_req_valid_out && imem_req_ready_in;

    // A redirect discards whatever response lands in the same cycle.
    assign drop_c = redirect_valid_in;
    assign push   = imem_rsp_valid_in && inflight && !drop_c;

    assign fq_valid_out = rst_n && !redirect_valid_in && (count != '0);
    assign pop          = fq_valid_out && fq_ready_in;
    assign fq_count_out = count;

    always_comb begin
        push_entry       = '0;
        push_entry.pc    = rsp_pc;
        push_entry.pc_4  = rsp_pc + XLEN'(PC_STEP);
        push_entry.instr = imem_rsp_data_in;
    end

    always_comb begin
        fq_pc_out    = '0;
        fq_pc_4_out  = '0;
        fq_instr_out = ILEN'(NOP_INSTR);
        if (fq_valid_out) begin
            fq_pc_out    = head.pc;
            fq_pc_4_out  = head.pc_4;
            fq_instr_out = head.instr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            rsp_pc   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= accept;
            if (redirect_valid_in) begin
                pc <= {redirect_target_in[XLEN-1:2], 2'b00};
            end else if (accept) begin
                pc     <= pc + XLEN'(PC_STEP);
                rsp_pc <= pc;
            end
        end
    end

    fetch_queue #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid_in),
        .push_data (push_entry),
        .head      (head),
        .count     (count)
    );

    // A response without an outstanding request is a memory protocol violation.
    a_rsp_has_req: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid_in |-> inflight);

endmodule

// File: tb/tb_fetch_unit_q.sv
// Self-checking bench for fetch_unit_q: imem model plus an in-order scoreboard of expected queue entries.
module tb_fetch_unit_q;
    import fetch_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned ILEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_4;
        logic [31:0] instr;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic            redirect_valid_in;
    logic [XLEN-1:0] redirect_target_in;
    logic            imem_req_valid_out;
    logic            imem_req_ready_in;
    logic [XLEN-1:0] imem_addr_out;
    logic            imem_rsp_valid_in;
    logic [ILEN-1:0] imem_rsp_data_in;
    logic            fq_valid_out;
    logic            fq_ready_in;
    logic [XLEN-1:0] fq_pc_out;
    logic [XLEN-1:0] fq_pc_4_out;
    logic [ILEN-1:0] fq_instr_out;
    logic [CW-1:0]   fq_count_out;

    fetch_unit_q #(
        .XLEN     (XLEN),
        .ILEN     (ILEN),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .redirect_valid_in  (redirect_valid_in),
        .redirect_target_in (redirect_target_in),
        .imem_req_valid_out (imem_req_valid_out),
        .imem_req_ready_in  (imem_req_ready_in),
        .imem_addr_out      (imem_addr_out),
        .imem_rsp_valid_in  (imem_rsp_valid_in),
        .imem_rsp_data_in   (imem_rsp_data_in),
        .fq_valid_out       (fq_valid_out),
        .fq_ready_in        (fq_ready_in),
        .fq_pc_out          (fq_pc_out),
        .fq_pc_4_out        (fq_pc_4_out),
        .fq_instr_out       (fq_instr_out),
        .fq_count_out       (fq_count_out)
    );

    always #5 clk = ~clk;

    int          checks;
    int          errors;
    exp_t        exp_q[$];
    logic [31:0] m_pc;
    logic        obs_req;
    logic        obs_fqv;
    logic [CW-1:0] obs_count;
    logic [31:0] obs_addr;
    logic        pop_seen;
    logic [31:0] first_pop_pc;
    logic [31:0] held_addr;
    logic        found;

    // Distinct word per address: halves swapped, then xored with a tag.
    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: entered at a negedge with inputs already driven; returns at the next negedge.
    task automatic tick();
        logic        acc;
        logic        pop;
        logic [31:0] a;
        exp_t        e;
        #1;
        obs_req   = imem_req_valid_out;
        obs_fqv   = fq_valid_out;
        obs_count = fq_count_out;
        obs_addr  = imem_addr_out;
        acc = rst_n && obs_req && imem_req_ready_in;
        pop = obs_fqv && fq_ready_in;
        a   = obs_addr;
        if (acc) begin
            check_eq("req_addr", obs_addr, m_pc);
            exp_q.push_back('{m_pc, m_pc + 32'd4, word(m_pc)});
            m_pc = m_pc + 32'd4;
        end
        if (pop) begin
            check_eq("pop_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("pop_pc", fq_pc_out, e.pc);
                check_eq("pop_pc_4", fq_pc_4_out, e.pc_4);
                check_eq("pop_instr", fq_instr_out, e.instr);
                if (!pop_seen) begin
                    pop_seen     = 1'b1;
                    first_pop_pc = fq_pc_out;
                end
            end
        end
        if (redirect_valid_in) begin
            exp_q.delete();
            m_pc = {redirect_target_in[31:2], 2'b00};
        end
        @(posedge clk);
        @(negedge clk);
        imem_rsp_valid_in = acc;
        imem_rsp_data_in  = acc ? word(a) : 32'h0;
    endtask

    initial begin
        clk                = 1'b0;
        rst_n              = 1'b0;
        redirect_valid_in  = 1'b0;
        redirect_target_in = '0;
        imem_req_ready_in  = 1'b1;
        imem_rsp_valid_in  = 1'b0;
        imem_rsp_data_in   = '0;
        fq_ready_in        = 1'b1;
        checks             = 0;
        errors             = 0;
        m_pc               = 32'h0;
        pop_seen           = 1'b0;
        first_pop_pc       = '0;
        found              = 1'b0;

        // Reset state
        #2;
        check_eq("rst_fq_valid", 32'(fq_valid_out), 32'd0);
        check_eq("rst_instr", fq_instr_out, 32'h0000_0013);
        check_eq("rst_pc", fq_pc_out, 32'h0);
        check_eq("rst_pc_4", fq_pc_4_out, 32'h0);
        check_eq("rst_count", 32'(fq_count_out), 32'd0);
        check_eq("rst_req_valid", 32'(imem_req_valid_out), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: first-fetch latency and streaming
        tick();
        check_eq("t1_req_c0", 32'(obs_req), 32'd1);
        check_eq("t1_valid_c0", 32'(obs_fqv), 32'd0);
        tick();
        check_eq("t1_valid_c1", 32'(obs_fqv), 32'd0);
        tick();
        check_eq("t1_valid_c2", 32'(obs_fqv), 32'd1);
        check_eq("t1_first_pc", first_pop_pc, 32'h0);
        repeat (6) tick();

        // 2: decode stall fills the queue, issue stops, resumes after first pop
        fq_ready_in = 1'b0;
        repeat (10) tick();
        check_eq("t2_count_full", 32'(obs_count), 32'd4);
        check_eq("t2_req_stopped", 32'(obs_req), 32'd0);
        fq_ready_in = 1'b1;
        tick();
        check_eq("t2_req_at_pop", 32'(obs_req), 32'd0);
        tick();
        check_eq("t2_req_resume", 32'(obs_req), 32'd1);
        repeat (8) tick();

        // 3: redirect with 3 queued and one in flight
        fq_ready_in = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (fq_count_out == CW'(3) && imem_rsp_valid_in) found = 1'b1;
            else tick();
        end
        check_eq("t3_setup", 32'(found), 32'd1);
        redirect_valid_in  = 1'b1;
        redirect_target_in = 32'h100;
        fq_ready_in        = 1'b1;
        pop_seen           = 1'b0;
        tick();
        check_eq("t3_valid_in_redirect", 32'(obs_fqv), 32'd0);
        check_eq("t3_no_req_in_redirect", 32'(obs_req), 32'd0);
        redirect_valid_in = 1'b0;
        tick();
        check_eq("t3_count_flushed", 32'(obs_count), 32'd0);
        repeat (4) tick();
        check_eq("t3_first_pc", first_pop_pc, 32'h100);

        // 4: misaligned target, then back-to-back redirects
        redirect_valid_in  = 1'b1;
        redirect_target_in = 32'h203;
        tick();
        redirect_valid_in = 1'b0;
        tick();
        check_eq("t4_aligned_addr", obs_addr, 32'h200);
        repeat (3) tick();
        pop_seen           = 1'b0;
        redirect_valid_in  = 1'b1;
        redirect_target_in = 32'h40;
        tick();
        redirect_target_in = 32'h80;
        tick();
        redirect_valid_in = 1'b0;
        repeat (5) tick();
        check_eq("t4_last_redirect_wins", first_pop_pc, 32'h80);

        // 5: imem backpressure, then PC wrap
        imem_req_ready_in = 1'b1;
        tick();
        imem_req_ready_in = 1'b0;
        tick();
        held_addr = obs_addr;
        tick();
        check_eq("t5_pc_hold", obs_addr, held_addr);
        imem_req_ready_in = 1'b1;
        tick();
        check_eq("t5_pc_retry", obs_addr, held_addr);
        repeat (4) tick();
        pop_seen           = 1'b0;
        redirect_valid_in  = 1'b1;
        redirect_target_in = 32'hFFFF_FFFC;
        tick();
        redirect_valid_in = 1'b0;
        tick();
        tick();
        check_eq("t5_wrap_addr", obs_addr, 32'h0);
        repeat (4) tick();
        check_eq("t5_wrap_first_pc", first_pop_pc, 32'hFFFF_FFFC);

        // 6: asynchronous reset mid-stream
        fq_ready_in = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (fq_count_out == CW'(3)) found = 1'b1;
            else tick();
        end
        check_eq("t6_setup", 32'(found), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_valid", 32'(fq_valid_out), 32'd0);
        check_eq("t6_rst_instr", fq_instr_out, 32'h0000_0013);
        check_eq("t6_rst_count", 32'(fq_count_out), 32'd0);
        check_eq("t6_rst_req", 32'(imem_req_valid_out), 32'd0);
        exp_q.delete();
        m_pc              = 32'h0;
        imem_rsp_valid_in = 1'b0;
        imem_rsp_data_in  = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n       = 1'b1;
        fq_ready_in = 1'b1;
        pop_seen    = 1'b0;
        tick();
        check_eq("t6_restart_addr", obs_addr, 32'h0);
        repeat (4) tick();
        check_eq("t6_first_pc", first_pop_pc, 32'h0);

        // Drain: nothing lost, nothing left over
        imem_req_ready_in = 1'b0;
        repeat (8) tick();
        check_eq("drain_count", 32'(fq_count_out), 32'd0);
        check_eq("drain_model_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
